// File: rtl/mux_pkg.sv
// Shared constants for the word-multiplexer slice: default data width and
// select encoding.
package mux_pkg;

  localparam int unsigned MUX_WIDTH_DEFAULT = 8;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_sel_comb.sv
// Parameterised combinational two-way word selector; an unknown select
// yields an unknown word rather than a bitwise merge of the inputs.
module mux_sel_comb
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = 'x;
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux_2to1.sv
// Two-input WIDTH-bit word mux with a combinational output, a registered
// copy of the selected word and select, and a registered select-change pulse.
module mux_2to1
  import mux_pkg::*;
#(
  parameter int unsigned     WIDTH     = MUX_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SEL,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_Q,
  output logic             SEL_Q,
  output logic             SEL_CHG
);

  logic [WIDTH-1:0] sel_word;

  mux_sel_comb #(
    .WIDTH(WIDTH)
  ) u_sel (
    .a  (A),
    .b  (B),
    .sel(SEL),
    .y  (sel_word)
  );

  assign Y = sel_word;

  // The change pulse compares against the pre-edge SEL_Q, so a select that
  // toggles every cycle holds SEL_CHG high continuously.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y_Q     <= RESET_VAL;
      SEL_Q   <= SEL_A;
      SEL_CHG <= 1'b0;
    end else begin
      Y_Q     <= sel_word;
      SEL_Q   <= SEL;
      SEL_CHG <= (SEL != SEL_Q);
    end
  end

endmodule

// File: tb/tb_mux_2to1.sv
// Directed self-checking bench for mux_2to1: default 8-bit instance plus a
// 16-bit instance with a non-zero reset value.
module tb_mux_2to1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, sel1;
  logic [7:0]  a1, b1, y1, yq1;
  logic        selq1, chg1;

  logic        rst2, sel2;
  logic [15:0] a2, b2, y2, yq2;
  logic        selq2, chg2;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mux_2to1 u_dut8 (
    .clk    (clk),
    .rst    (rst1),
    .A      (a1),
    .B      (b1),
    .SEL    (sel1),
    .Y      (y1),
    .Y_Q    (yq1),
    .SEL_Q  (selq1),
    .SEL_CHG(chg1)
  );

  mux_2to1 #(
    .WIDTH    (16),
    .RESET_VAL(16'h003C)
  ) u_dut16 (
    .clk    (clk),
    .rst    (rst2),
    .A      (a2),
    .B      (b2),
    .SEL    (sel2),
    .Y      (y2),
    .Y_Q    (yq2),
    .SEL_Q  (selq2),
    .SEL_CHG(chg2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs1(input string tag, input logic [7:0] yq,
                             input logic sq, input logic chg);
    check({tag, ".y_q"},    32'(yq1),   32'(yq));
    check({tag, ".sel_q"},  32'(selq1), 32'(sq));
    check({tag, ".sel_chg"}, 32'(chg1), 32'(chg));
  endtask

  initial begin
    rst1 = 1'b1; a1 = 8'h55; b1 = 8'hAA; sel1 = 1'b0;
    rst2 = 1'b1; a2 = 16'h0000; b2 = 16'h0000; sel2 = 1'b0;

    // combinational path, no edge needed
    #1;   check("comb_a",  32'(y1), 32'h55);
    sel1 = 1'b1; #1; check("comb_b",  32'(y1), 32'hAA);
    sel1 = 1'b0; #1; check("comb_a2", 32'(y1), 32'h55);

    // two reset edges
    tick(); check_regs1("rst_e1", 8'h00, 1'b0, 1'b0); check("rst_e1.y", 32'(y1), 32'h55);
    tick(); check_regs1("rst_e2", 8'h00, 1'b0, 1'b0); check("rst_e2.y", 32'(y1), 32'h55);
    check("rst16.y_q", 32'(yq2), 32'h003C);
    check("rst16.sel_q", 32'(selq2), 32'h0);

    // release, select B
    rst1 = 1'b0; sel1 = 1'b1; b1 = 8'hAA;
    tick(); check_regs1("selb", 8'hAA, 1'b1, 1'b1);
    tick(); check_regs1("selb_hold", 8'hAA, 1'b1, 1'b0);

    // toggle every cycle keeps the pulse high
    sel1 = 1'b0; tick(); check_regs1("tog1", 8'h55, 1'b0, 1'b1);
    sel1 = 1'b1; tick(); check_regs1("tog2", 8'hAA, 1'b1, 1'b1);
    sel1 = 1'b0; tick(); check_regs1("tog3", 8'h55, 1'b0, 1'b1);

    // data change between edges with SEL held at 0
    a1 = 8'h01; tick(); check_regs1("a01", 8'h01, 1'b0, 1'b0);
    a1 = 8'hFE; #1;
    check("afe.y",   32'(y1),  32'hFE);
    check("afe.y_q", 32'(yq1), 32'h01);
    tick(); check("afe_edge.y_q", 32'(yq1), 32'hFE);

    // reset together with data/select change: nothing captured
    rst1 = 1'b1; sel1 = 1'b1; a1 = 8'h33; b1 = 8'hC4;
    tick(); check_regs1("midrst", 8'h00, 1'b0, 1'b0);
    check("midrst.y", 32'(y1), 32'hC4);

    // same scenario on the 16-bit instance with RESET_VAL=0x3C
    rst2 = 1'b0; a2 = 16'h1234; sel2 = 1'b0;
    tick();
    check("w16.y_q", 32'(yq2), 32'h1234);
    rst2 = 1'b1; sel2 = 1'b1; a2 = 16'hBEEF; b2 = 16'hCAFE;
    tick();
    check("w16_midrst.y_q",     32'(yq2),   32'h003C);
    check("w16_midrst.sel_q",   32'(selq2), 32'h0);
    check("w16_midrst.sel_chg", 32'(chg2),  32'h0);
    check("w16_midrst.y",       32'(y2),    32'hCAFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
